// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - Execute-to-writeback bundle and commit ports
// The writeback unit takes the slave modport; the Execute/memory/regfile side takes master.
interface writeback_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              isExecuteSuccessfulIn;
  logic              killIn;
  logic [DATA_W-1:0] aluResultIn;
  logic [DATA_W-1:0] aluResultSpecialIn;
  logic [3:0]        destRegIn;
  logic              destRegValidIn;
  logic [3:0]        destRegSpecialIn;
  logic              destRegSpecialValidIn;
  logic              isMemoryAccessDestIn;
  logic [ADDR_W-1:0] memoryAddressDestIn;
  logic              memWriteAckIn;

  logic              wbStallOut;
  logic              regWriteEnOut;
  logic [3:0]        regWriteAddrOut;
  logic [DATA_W-1:0] regWriteDataOut;
  logic              regWriteSpecialEnOut;
  logic [3:0]        regWriteSpecialAddrOut;
  logic [DATA_W-1:0] regWriteSpecialDataOut;
  logic              memWriteReqOut;
  logic [ADDR_W-1:0] memWriteAddrOut;
  logic [DATA_W-1:0] memWriteDataOut;
  logic              haltOut;
  logic [63:0]       retiredCountOut;

  modport slave (
    input  isExecuteSuccessfulIn, killIn, aluResultIn, aluResultSpecialIn,
           destRegIn, destRegValidIn, destRegSpecialIn, destRegSpecialValidIn,
           isMemoryAccessDestIn, memoryAddressDestIn, memWriteAckIn,
    output wbStallOut, regWriteEnOut, regWriteAddrOut, regWriteDataOut,
           regWriteSpecialEnOut, regWriteSpecialAddrOut, regWriteSpecialDataOut,
           memWriteReqOut, memWriteAddrOut, memWriteDataOut, haltOut, retiredCountOut
  );

  modport master (
    output isExecuteSuccessfulIn, killIn, aluResultIn, aluResultSpecialIn,
           destRegIn, destRegValidIn, destRegSpecialIn, destRegSpecialValidIn,
           isMemoryAccessDestIn, memoryAddressDestIn, memWriteAckIn,
    input  wbStallOut, regWriteEnOut, regWriteAddrOut, regWriteDataOut,
           regWriteSpecialEnOut, regWriteSpecialAddrOut, regWriteSpecialDataOut,
           memWriteReqOut, memWriteAddrOut, memWriteDataOut, haltOut, retiredCountOut
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - commits Execute results to the register file and data memory
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNTER_EN.
module writeback_unit #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic            clk,
  input  logic            reset_n,
  writeback_unit_if.slave wb
);
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEM_REQ = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic              w_capture;
  logic              w_kill_cap;
  logic              w_store_cap;
  logic              w_reg_cap;
  logic              w_ack;

  logic              w_a_en;
  logic              w_b_en;
  logic              w_req;
  logic              w_halt;

  logic              r_a_en;
  logic [3:0]        r_a_addr;
  logic [DATA_W-1:0] r_a_data;
  logic              r_b_en;
  logic [3:0]        r_b_addr;
  logic [DATA_W-1:0] r_b_data;
  logic              r_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_halt;

  // Bundles are consumed only in IDLE; kill takes priority over any destination.
  assign w_capture   = (r_state == ST_IDLE) && wb.isExecuteSuccessfulIn;
  assign w_kill_cap  = w_capture && wb.killIn;
  assign w_store_cap = w_capture && !wb.killIn && wb.isMemoryAccessDestIn;
  assign w_reg_cap   = w_capture && !wb.killIn && !wb.isMemoryAccessDestIn;
  assign w_ack       = (r_state == ST_MEM_REQ) && wb.memWriteAckIn;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_kill_cap) begin
          w_state_next = ST_HALTED;
        end else if (w_store_cap) begin
          w_state_next = ST_MEM_REQ;
        end
      end
      ST_MEM_REQ: begin
        if (w_ack) begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HALTED: w_state_next = ST_HALTED;
      default:   w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_a_en = 1'b0;
    w_b_en = 1'b0;
    w_req  = 1'b0;
    w_halt = r_halt;
    // Port B wins a same-register collision, so port A is dropped.
    w_a_en = w_reg_cap && wb.destRegValidIn &&
             !(wb.destRegSpecialValidIn && (wb.destRegIn == wb.destRegSpecialIn));
    w_b_en = w_capture && !wb.killIn && wb.destRegSpecialValidIn;
    w_req  = w_store_cap || ((r_state == ST_MEM_REQ) && !wb.memWriteAckIn);
    w_halt = r_halt || w_kill_cap;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_a_en     <= 1'b0;
      r_a_addr   <= '0;
      r_a_data   <= '0;
      r_b_en     <= 1'b0;
      r_b_addr   <= '0;
      r_b_data   <= '0;
      r_req      <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_halt     <= 1'b0;
    end else begin
      r_a_en <= w_a_en;
      r_b_en <= w_b_en;
      r_req  <= w_req;
      r_halt <= w_halt;
      if (w_a_en) begin
        r_a_addr <= wb.destRegIn;
        r_a_data <= wb.aluResultIn;
      end
      if (w_b_en) begin
        r_b_addr <= wb.destRegSpecialIn;
        r_b_data <= wb.aluResultSpecialIn;
      end
      if (w_store_cap) begin
        r_mem_addr <= wb.memoryAddressDestIn;
        r_mem_data <= wb.aluResultIn;
      end
    end
  end

`ifdef WB_RETIRE_COUNTER_EN
  logic        w_retire;
  logic [63:0] r_retired_count;

  // Stores retire when memory acknowledges, everything else at capture.
  assign w_retire = w_kill_cap || w_reg_cap || w_ack;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_retired_count <= 64'd0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + 64'd1;
    end
  end

  assign wb.retiredCountOut = r_retired_count;
`else
  assign wb.retiredCountOut = 64'd0;
`endif

  assign wb.wbStallOut             = (r_state == ST_MEM_REQ) || (r_state == ST_HALTED);
  assign wb.regWriteEnOut          = r_a_en;
  assign wb.regWriteAddrOut        = r_a_addr;
  assign wb.regWriteDataOut        = r_a_data;
  assign wb.regWriteSpecialEnOut   = r_b_en;
  assign wb.regWriteSpecialAddrOut = r_b_addr;
  assign wb.regWriteSpecialDataOut = r_b_data;
  assign wb.memWriteReqOut         = r_req;
  assign wb.memWriteAddrOut        = r_mem_addr;
  assign wb.memWriteDataOut        = r_mem_data;
  assign wb.haltOut                = r_halt;
endmodule
